// File: rtl/fsm_lights_timed.sv
// fsm_lights_timed: two-street traffic-light controller with timed yellow phases.
//
// Street A and street B alternate right-of-way based on car sensors. Parade
// mode (M) holds street B green. Each yellow phase lasts exactly YELLOW_CYCLES
// clocks, timed by a saturating up-counter that restarts on every state change.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-high
//   TA     - car present on street A
//   TB     - car present on street B
//   M      - parade mode (1 = hold street B green)
//   LA     - street A lamp: 00 green, 01 yellow, 10 red
//   LB     - street B lamp: same encoding as LA
//   state  - current FSM state (0..3), for observation
//
// Build option: define MIN_GREEN_EN to make each green phase last at least
// MIN_GREEN_CYCLES cycles before the sensors may end it.

module fsm_lights_timed #(
   parameter int unsigned YELLOW_CYCLES    = 5,
   parameter int unsigned MIN_GREEN_CYCLES = 8,
   parameter int unsigned TIMER_W          = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       TA,
   input  logic       TB,
   input  logic       M,
   output logic [1:0] LA,
   output logic [1:0] LB,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      S0 = 2'd0,  // A green,  B red
      S1 = 2'd1,  // A yellow, B red
      S2 = 2'd2,  // A red,    B green
      S3 = 2'd3   // A red,    B yellow
   } state_t;

`ifdef MIN_GREEN_EN
   localparam logic MIN_GREEN_ON = 1'b1;
`else
   localparam logic MIN_GREEN_ON = 1'b0;
`endif

   localparam logic [TIMER_W-1:0] YEL_LAST   = TIMER_W'(YELLOW_CYCLES - 1);
   localparam logic [TIMER_W-1:0] GREEN_LAST = TIMER_W'(MIN_GREEN_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;

   state_t               state_q, state_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic                 green_done;
   logic                 yellow_done;

   // With the minimum-green option off, green may end on any cycle.
   assign green_done  = !MIN_GREEN_ON || (timer_q >= GREEN_LAST);
   assign yellow_done = (timer_q == YEL_LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S0:      if (!TA && green_done)       state_d = S1;
         S1:      if (yellow_done)             state_d = S2;
         S2:      if (!M && !TB && green_done) state_d = S3;
         S3:      if (yellow_done)             state_d = S0;
         default:                              state_d = S0;
      endcase
   end

   // Timer restarts on every state change and saturates instead of wrapping.
   always_comb begin
      timer_d = timer_q;
      if (state_d != state_q)
         timer_d = '0;
      else if (timer_q != TIMER_MAX)
         timer_d = timer_q + TIMER_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   // Moore outputs, decoded from the registered state only.
   always_comb begin
      LA = 2'b10;
      LB = 2'b10;
      case (state_q)
         S0:      LA = 2'b00;
         S1:      LA = 2'b01;
         S2:      LB = 2'b00;
         S3:      LB = 2'b01;
         default: begin
            LA = 2'b10;
            LB = 2'b10;
         end
      endcase
   end

   assign state = state_q;

endmodule
